column_dispatcher: RTL

Initiator side of the column-reduction handshake. Accepts a packed `size`×`size` matrix from the host sequencer and feeds it one column at a time to a downstream `column_adder`. It drives that adder's `in_ready`/`in_col`, consumes its `out_ready`/`out_cell`, and returns `out_ack`. The per-column sums are collected into one row vector, which is handed back upstream with the same ready/ack handshake.

---
 rtl/column_dispatcher_if.sv | 72 +++++++
 rtl/column_dispatcher.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_dispatcher_if.sv
// -----------------------------------------------------------------------------
// column_dispatcher_if
//   Bundles the two handshakes around column_dispatcher: the upstream matrix/row
//   channel to the host sequencer and the column channel to the column_adder.
//
//   Parameters
//     size        cells per column and number of columns
//     cell_width  bits per cell
//
//   Signals (directions seen from the dispatcher, i.e. the slave modport)
//     in_ready   in   upstream matrix valid
//     in_matrix  in   packed matrix, column j at [j*width +: width]
//     out_ack    in   upstream consumed out_row
//     out_ready  out  out_row valid
//     out_row    out  per-column sums, slot j at [j*cell_width +: cell_width]
//     out_error  out  watchdog fired
//     col_valid  out  to adder in_ready
//     col_data   out  to adder in_col
//     col_done   in   from adder out_ready
//     col_sum    in   from adder out_cell
//     col_ack    out  to adder out_ack
//
//   Modports
//     slave   the dispatcher itself
//     master  its environment (host sequencer plus column adder)
// -----------------------------------------------------------------------------
interface column_dispatcher_if #(
    parameter int size       = 4,
    parameter int cell_width = 32
);
    localparam int width = cell_width * size;

    logic                    in_ready;
    logic [width*size-1:0]   in_matrix;
    logic                    out_ack;
    logic                    out_ready;
    logic [width-1:0]        out_row;
    logic                    out_error;
    logic                    col_valid;
    logic [width-1:0]        col_data;
    logic                    col_done;
    logic [cell_width-1:0]   col_sum;
    logic                    col_ack;

    modport slave (
        input  in_ready,
        input  in_matrix,
        input  out_ack,
        output out_ready,
        output out_row,
        output out_error,
        output col_valid,
        output col_data,
        input  col_done,
        input  col_sum,
        output col_ack
    );

    modport master (
        output in_ready,
        output in_matrix,
        output out_ack,
        input  out_ready,
        input  out_row,
        input  out_error,
        input  col_valid,
        input  col_data,
        output col_done,
        output col_sum,
        input  col_ack
    );
endinterface

// File: rtl/column_dispatcher.sv
// -----------------------------------------------------------------------------
// column_dispatcher
//   Initiator side of the column-reduction handshake. Latches a size x size
//   matrix from the host, issues it one column at a time to a column_adder,
//   collects each returned sum bit-exact into one row vector and hands that row
//   back upstream with a ready/ack handshake.
//
//   Parameters
//     size        cells per column and number of columns
//     cell_width  bits per cell (IEEE-754 single, never interpreted here)
//     width       bits per column and per result row
//     timeout     watchdog limit in cycles (only with the macro below)
//
//   Ports
//     in_clk    in   clock, rising edge
//     in_reset  in   asynchronous active-high reset
//     bus       slave modport of column_dispatcher_if (host + adder channels)
//
//   Build option
//     COLUMN_DISPATCHER_TIMEOUT_EN  when defined, a per-state cycle counter in
//     ISSUE/DROP forces the row out with out_error=1 after `timeout` cycles.
//     When undefined no counter exists and out_error is tied 0.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for in_ready; matrix latched on acceptance
//   ISSUE | col_valid/col_data presented, waiting for col_done
//   ACK   | one-cycle col_ack pulse to the adder
//   DROP  | waiting for the adder to drop col_done before next column
//   DONE  | out_ready held with stable out_row until out_ack
// -----------------------------------------------------------------------------
module column_dispatcher #(
    parameter int size       = 4,
    parameter int cell_width = 32,
    parameter int width      = cell_width * size,
    parameter int timeout    = 1024
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    column_dispatcher_if.slave   bus
);

    localparam int IDX_W = $clog2(size + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ACK   = 3'd2,
        DROP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [width*size-1:0]   matrix_q, matrix_d;
    logic                    armed_q, armed_d;
    logic                    out_ready_q, out_ready_d;
    logic [width-1:0]        out_row_q, out_row_d;
    logic                    col_valid_q, col_valid_d;
    logic [width-1:0]        col_data_q, col_data_d;
    logic                    col_ack_q, col_ack_d;

`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
    localparam int WD_W = $clog2(timeout + 1);

    logic [WD_W-1:0]         wd_cnt_q, wd_cnt_d;
    logic                    out_error_q, out_error_d;
    logic                    wd_fire;
`endif

    // Column select by compare loop keeps the index width independent of the
    // part-select arithmetic.
    function automatic logic [width-1:0] column_of(
        input logic [width*size-1:0] m,
        input logic [IDX_W-1:0]      idx
    );
        logic [width-1:0] c;
        c = '0;
        for (int j = 0; j < size; j++) begin
            if (idx == IDX_W'(j)) begin
                c = m[j*width +: width];
            end
        end
        return c;
    endfunction

`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
    always_comb begin
        wd_fire = ((state_q == ISSUE) || (state_q == DROP)) && (wd_cnt_q == '0);
    end
`endif

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        matrix_d    = matrix_q;
        armed_d     = armed_q;
        out_ready_d = out_ready_q;
        out_row_d   = out_row_q;
        col_valid_d = col_valid_q;
        col_data_d  = col_data_q;
        col_ack_d   = 1'b0;
`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
        out_error_d = out_error_q;
        wd_cnt_d    = wd_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_ready) begin
                    matrix_d    = bus.in_matrix;
                    out_row_d   = '0;
                    index_d     = '0;
                    col_data_d  = column_of(bus.in_matrix, '0);
                    col_valid_d = 1'b1;
                    // A col_done already high here is stale; require a low first.
                    armed_d     = ~bus.col_done;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                if (!bus.col_done) begin
                    armed_d = 1'b1;
                end
                if (bus.col_done && armed_q) begin
                    for (int j = 0; j < size; j++) begin
                        if (index_q == IDX_W'(j)) begin
                            out_row_d[j*cell_width +: cell_width] = bus.col_sum;
                        end
                    end
                    col_valid_d = 1'b0;
                    col_ack_d   = 1'b1;
                    state_d     = ACK;
                end
            end

            ACK: begin
                state_d = DROP;
            end

            DROP: begin
                // The adder keeps col_done up one cycle past the ack.
                if (!bus.col_done) begin
                    if (index_q == IDX_W'(size - 1)) begin
                        out_ready_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        index_d     = index_q + IDX_W'(1);
                        col_data_d  = column_of(matrix_q, index_q + IDX_W'(1));
                        col_valid_d = 1'b1;
                        armed_d     = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end

            DONE: begin
                if (bus.out_ack) begin
                    out_ready_d = 1'b0;
`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
                    out_error_d = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
        // Watchdog overrides whatever the state decided this cycle.
        if (wd_fire) begin
            col_valid_d = 1'b0;
            col_ack_d   = 1'b0;
            out_error_d = 1'b1;
            out_ready_d = 1'b1;
            state_d     = DONE;
        end

        // Down-counter reloads on every state change and outside ISSUE/DROP.
        if ((state_d != state_q) || !((state_q == ISSUE) || (state_q == DROP))) begin
            wd_cnt_d = WD_W'(timeout - 1);
        end else if (wd_cnt_q != '0) begin
            wd_cnt_d = wd_cnt_q - WD_W'(1);
        end
`endif
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            matrix_q    <= '0;
            armed_q     <= 1'b0;
            out_ready_q <= 1'b0;
            out_row_q   <= '0;
            col_valid_q <= 1'b0;
            col_data_q  <= '0;
            col_ack_q   <= 1'b0;
`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
            out_error_q <= 1'b0;
            wd_cnt_q    <= WD_W'(timeout - 1);
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            matrix_q    <= matrix_d;
            armed_q     <= armed_d;
            out_ready_q <= out_ready_d;
            out_row_q   <= out_row_d;
            col_valid_q <= col_valid_d;
            col_data_q  <= col_data_d;
            col_ack_q   <= col_ack_d;
`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
            out_error_q <= out_error_d;
            wd_cnt_q    <= wd_cnt_d;
`endif
        end
    end

    assign bus.out_ready = out_ready_q;
    assign bus.out_row   = out_row_q;
    assign bus.col_valid = col_valid_q;
    assign bus.col_data  = col_data_q;
    assign bus.col_ack   = col_ack_q;
`ifdef COLUMN_DISPATCHER_TIMEOUT_EN
    assign bus.out_error = out_error_q;
`else
    assign bus.out_error = 1'b0;
`endif

endmodule
